// File: rtl/ms_dsc_mul_engine.sv
// ms_dsc_mul_engine
// Deterministic stochastic-computing N-input multiplier with a start/done
// handshake. Each operand drives a unary stream generator that emits
// 2^STRIDE_LOG2 bits per step. The generator counters advance like an
// odometer: c_0 steps every cycle and c_i steps when all lower counters wrap.
// All cross-product lanes are ANDed and their popcount accumulated, so the
// accumulator ends up holding the exact binary product.
//
// Optional build macro: MS_DSC_EARLY_TERM_EN
//   When defined, RUN exits as soon as the remaining lanes can only be zero:
//   either some latched operand is zero, or the top counter has moved past
//   its operand.

module ms_dsc_mul_engine #(
    parameter int DATA_WIDTH  = 5,
    parameter int NUM_INPUTS  = 2,
    parameter int STRIDE_LOG2 = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic                             en,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] bin_data_in,
    output logic                             busy,
    output logic                             done,
    output logic [NUM_INPUTS*DATA_WIDTH-1:0] bin_data_out
);

    localparam int unsigned W  = DATA_WIDTH;
    localparam int unsigned N  = NUM_INPUTS;
    localparam int unsigned SL = STRIDE_LOG2;
    localparam int unsigned S  = 32'd1 << SL;
    localparam int unsigned CW = W - SL;
    localparam int unsigned NL = 32'd1 << (SL * N);
    localparam int unsigned OW = W * N;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            w_accept;
    logic            w_step;

    logic [W-1:0]    r_x       [N];
    logic [CW-1:0]   r_cnt     [N];
    logic [CW-1:0]   w_cnt_nxt [N];
    logic [OW-1:0]   r_acc;

    logic [W:0]      w_base    [N];
    logic [S-1:0]    w_gen     [N];
    logic [OW-1:0]   w_step_sum;
    logic            w_lane;
    logic            w_carry;
    logic            w_all_max;
    logic            w_last_step;

    // Unary generators: bit k of operand i is set while c_i*S + k < x_i.
    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            w_base[i] = (W+1)'(r_cnt[i]) << SL;
            for (int unsigned k = 0; k < S; k++) begin
                w_gen[i][k] = (w_base[i] + (W+1)'(k)) < (W+1)'(r_x[i]);
            end
        end
    end

    // Full cross product: lane l picks bit ((l >> i*SL) mod S) from generator i.
    always_comb begin
        w_step_sum = '0;
        w_lane     = 1'b0;
        for (int unsigned l = 0; l < NL; l++) begin
            w_lane = 1'b1;
            for (int unsigned i = 0; i < N; i++) begin
                w_lane = w_lane &
                         (|(w_gen[i] & (S'(1) << ((l >> (i * SL)) & (S - 1)))));
            end
            w_step_sum = w_step_sum + OW'(w_lane);
        end
    end

    // Odometer-style counter advance; the final carry marks the last step.
    always_comb begin
        w_carry = 1'b1;
        for (int unsigned i = 0; i < N; i++) begin
            w_cnt_nxt[i] = r_cnt[i] + CW'(w_carry);
            w_carry      = w_carry & (r_cnt[i] == '1);
        end
        w_all_max = w_carry;
    end

`ifdef MS_DSC_EARLY_TERM_EN
    logic w_zero_op;
    logic w_tail_dead;

    // Stop once every remaining lane is provably zero.
    always_comb begin
        w_zero_op = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (r_x[i] == '0) begin
                w_zero_op = 1'b1;
            end
        end
        w_tail_dead = ((W+1)'(w_cnt_nxt[N-1]) << SL) >= (W+1)'(r_x[N-1]);
        w_last_step = w_all_max | w_zero_op | w_tail_dead;
    end
`else
    assign w_last_step = w_all_max;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic with start acceptance and step qualification.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_step      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (en) begin
                    w_step = 1'b1;
                    if (w_last_step) begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Operand latch, counters and accumulator.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
            for (int unsigned i = 0; i < N; i++) begin
                r_x[i]   <= '0;
                r_cnt[i] <= '0;
            end
        end else if (w_accept) begin
            r_acc <= '0;
            for (int unsigned i = 0; i < N; i++) begin
                r_x[i]   <= bin_data_in[i*W +: W];
                r_cnt[i] <= '0;
            end
        end else if (w_step) begin
            r_acc <= r_acc + w_step_sum;
            for (int unsigned i = 0; i < N; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
        end
    end

    assign busy         = (r_state == ST_RUN);
    assign done         = (r_state == ST_DONE);
    assign bin_data_out = r_acc;

endmodule

// File: tb/tb_ms_dsc_mul_engine.sv
// Testbench for ms_dsc_mul_engine: three instances with different geometry
// (W/N/S = 4/2/2, 5/3/4, 4/1/4) share one clock and reset. Expected products
// and step counts come from plain arithmetic on the operands.

module tb_ms_dsc_mul_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  start_v;
    logic [2:0]  en_v;
    logic [2:0]  busy_v;
    logic [2:0]  done_v;
    logic        a_busy, b_busy, c_busy;
    logic        a_done, b_done, c_done;
    logic [7:0]  a_din, a_out;
    logic [14:0] b_din, b_out;
    logic [3:0]  c_din, c_out;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ms_dsc_mul_engine #(.DATA_WIDTH(4), .NUM_INPUTS(2), .STRIDE_LOG2(1)) u_a (
        .clk(clk), .rst(rst), .start(start_v[0]), .en(en_v[0]),
        .bin_data_in(a_din), .busy(a_busy), .done(a_done), .bin_data_out(a_out)
    );

    ms_dsc_mul_engine #(.DATA_WIDTH(5), .NUM_INPUTS(3), .STRIDE_LOG2(2)) u_b (
        .clk(clk), .rst(rst), .start(start_v[1]), .en(en_v[1]),
        .bin_data_in(b_din), .busy(b_busy), .done(b_done), .bin_data_out(b_out)
    );

    ms_dsc_mul_engine #(.DATA_WIDTH(4), .NUM_INPUTS(1), .STRIDE_LOG2(2)) u_c (
        .clk(clk), .rst(rst), .start(start_v[2]), .en(en_v[2]),
        .bin_data_in(c_din), .busy(c_busy), .done(c_done), .bin_data_out(c_out)
    );

    assign busy_v = {c_busy, b_busy, a_busy};
    assign done_v = {c_done, b_done, a_done};

    typedef struct {
        int d;
        int x0;
        int x1;
        int x2;
        int exp;
        bit rnd;
    } vec_t;

    vec_t tbl[$];

    function automatic int out_of(input int d);
        case (d)
            0:       return int'(a_out);
            1:       return int'(b_out);
            default: return int'(c_out);
        endcase
    endfunction

    function automatic void cfg(input int d, output int w, output int n, output int sl);
        case (d)
            0:       begin w = 4; n = 2; sl = 1; end
            1:       begin w = 5; n = 3; sl = 2; end
            default: begin w = 4; n = 1; sl = 2; end
        endcase
    endfunction

    function automatic int model_product(input int d, input int x0, input int x1, input int x2);
        int w, n, sl;
        cfg(d, w, n, sl);
        return x0 * ((n > 1) ? x1 : 1) * ((n > 2) ? x2 : 1);
    endfunction

    // Number of RUN steps the engine needs for these operands.
    function automatic int model_steps(input int d, input int x0, input int x1, input int x2);
        int w, n, sl, s, cw, xl, k;
        bit anyz;
        cfg(d, w, n, sl);
        s    = 1 << sl;
        cw   = w - sl;
        xl   = (n == 1) ? x0 : ((n == 2) ? x1 : x2);
        anyz = (x0 == 0) || (n > 1 && x1 == 0) || (n > 2 && x2 == 0);
        k    = 0;
`ifdef MS_DSC_EARLY_TERM_EN
        if (anyz) return 1;
        k = (xl + s - 1) / s;
        if (k < 1) k = 1;
        return k << (cw * (n - 1));
`else
        if (anyz || xl < 0 || k < 0) k = 0;
        return 1 << (cw * n);
`endif
    endfunction

    // Accumulated ones after j steps for the W=4,N=2,S=2 instance.
    function automatic int partial_a(input int x0, input int x1, input int steps);
        int acc, n0, n1;
        acc = 0;
        for (int j = 0; j < steps; j++) begin
            n0 = x0 - 2 * (j % 8);
            n1 = x1 - 2 * (j / 8);
            n0 = (n0 < 0) ? 0 : ((n0 > 2) ? 2 : n0);
            n1 = (n1 < 0) ? 0 : ((n1 > 2) ? 2 : n1);
            acc += n0 * n1;
        end
        return acc;
    endfunction

    task automatic check(input string name, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Called at a negedge; drives start for one edge, then scrambles operands.
    task automatic pulse_start(input int d, input int x0, input int x1, input int x2);
        case (d)
            0:       a_din = {4'(x1), 4'(x0)};
            1:       b_din = {5'(x2), 5'(x1), 5'(x0)};
            default: c_din = 4'(x0);
        endcase
        start_v[d] = 1'b1;
        @(negedge clk);
        start_v[d] = 1'b0;
        a_din = 8'($urandom);
        b_din = 15'($urandom);
        c_din = 4'($urandom);
    endtask

    // Waits (bounded) for done, optionally toggling en, and checks timing/result.
    task automatic run_wait(input int d, input int start_cyc, input bit rnd,
                            input int exp_res, input int exp_steps, input string name);
        int cyc, lows, busy_n;
        cyc    = start_cyc;
        lows   = 0;
        busy_n = 0;
        if (start_cyc == 1) check({name, ".clr"}, out_of(d), 0);
        while (!done_v[d] && cyc < start_cyc + 4000) begin
            if (busy_v[d]) begin
                busy_n++;
                en_v[d] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                if (!en_v[d]) lows++;
            end
            @(negedge clk);
            cyc++;
        end
        en_v[d] = 1'b1;
        check({name, ".done"}, int'(done_v[d]), 1);
        check({name, ".cycle"}, cyc, exp_steps + lows + 1);
        check({name, ".busy"}, busy_n, exp_steps + lows - (start_cyc - 1));
        check({name, ".res"}, out_of(d), exp_res);
    endtask

    task automatic idle_check(input int d, input int exp_res, input string name);
        @(negedge clk);
        check({name, ".idle_done"}, int'(done_v[d]), 0);
        check({name, ".idle_busy"}, int'(busy_v[d]), 0);
        check({name, ".hold"}, out_of(d), exp_res);
    endtask

    task automatic run_case(input int d, input int x0, input int x1, input int x2,
                            input int exp_res, input bit rnd, input string name);
        pulse_start(d, x0, x1, x2);
        run_wait(d, 1, rnd, exp_res, model_steps(d, x0, x1, x2), name);
        idle_check(d, exp_res, name);
    endtask

    initial begin
        int x0, x1, x2;
        rst     = 1'b1;
        start_v = '0;
        en_v    = '1;
        a_din   = '0;
        b_din   = '0;
        c_din   = '0;

        tbl.push_back('{0, 15, 15, 0, 225, 1'b0});
        tbl.push_back('{0,  5,  3, 0,  15, 1'b0});
        tbl.push_back('{0,  0,  9, 0,   0, 1'b0});
        tbl.push_back('{0, 15,  2, 0,  30, 1'b0});
        tbl.push_back('{1, 31, 17, 6, 3162, 1'b0});
        tbl.push_back('{1, 31, 17, 6, 3162, 1'b1});
        tbl.push_back('{2,  9,  0, 0,   9, 1'b0});
        tbl.push_back('{2,  0,  0, 0,   0, 1'b0});
        tbl.push_back('{2, 15,  0, 0,  15, 1'b1});

        repeat (2) @(negedge clk);
        check("rst.busy", int'(busy_v), 0);
        check("rst.done", int'(done_v), 0);
        check("rst.a_out", out_of(0), 0);
        check("rst.b_out", out_of(1), 0);
        check("rst.c_out", out_of(2), 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < tbl.size(); i++) begin
            run_case(tbl[i].d, tbl[i].x0, tbl[i].x1, tbl[i].x2, tbl[i].exp,
                     tbl[i].rnd, $sformatf("vec%0d", i));
        end

        // Start re-pulsed mid-RUN is ignored; then a start in the done cycle.
        pulse_start(0, 15, 15, 0);
        repeat (10) @(negedge clk);
        pulse_start(0, 1, 1, 0);
        run_wait(0, 12, 1'b0, 225, model_steps(0, 15, 15, 0), "restart");
        pulse_start(0, 2, 7, 0);
        run_wait(0, 1, 1'b0, 14, model_steps(0, 2, 7, 0), "done_start");
        idle_check(0, 14, "done_start");

        // Reset in the middle of a run.
        pulse_start(0, 15, 15, 0);
        repeat (19) @(negedge clk);
        check("mid.partial", out_of(0), partial_a(15, 15, 19));
        rst = 1'b1;
        #1;
        check("mid_rst.busy", int'(a_busy), 0);
        check("mid_rst.done", int'(a_done), 0);
        check("mid_rst.out", out_of(0), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst.done", int'(a_done), 0);
        check("post_rst.busy", int'(a_busy), 0);
        run_case(0, 4, 4, 0, 16, 1'b0, "after_rst");

        // Randomised operands against the arithmetic model.
        for (int i = 0; i < 12; i++) begin
            x0 = $urandom_range(0, 15);
            x1 = $urandom_range(0, 15);
            run_case(0, x0, x1, 0, model_product(0, x0, x1, 0), 1'($urandom_range(0, 1)),
                     $sformatf("rnd_a%0d", i));
        end
        for (int i = 0; i < 3; i++) begin
            x0 = $urandom_range(0, 31);
            x1 = $urandom_range(0, 31);
            x2 = $urandom_range(0, 31);
            run_case(1, x0, x1, x2, model_product(1, x0, x1, x2), 1'($urandom_range(0, 1)),
                     $sformatf("rnd_b%0d", i));
        end
        for (int i = 0; i < 6; i++) begin
            x0 = $urandom_range(0, 15);
            run_case(2, x0, 0, 0, model_product(2, x0, 0, 0), 1'($urandom_range(0, 1)),
                     $sformatf("rnd_c%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
